puf_tx_serializer: RTL

PUF_TX_SERIALIZER -- requirements
Module: puf_tx_serializer

---
 rtl/puf_tx_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/puf_tx_serializer.sv
// -----------------------------------------------------------------------------
// puf_tx_serializer
//
// Purpose:
//   Takes one parallel frame from the PUF core and shifts it out to the host
//   one bit at a time, LSB first, under a valid/ready handshake. A normal-mode
//   frame sends NORM_MOD bits and a debug-mode frame sends DEBUG_MOD bits. Any
//   payload bits above the latched length are never transmitted. The FSM runs
//   IDLE -> SHIFT -> DONE -> IDLE, and DONE lasts exactly one cycle.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   i_frame_valid  in   parallel frame offered
//   o_frame_ready  out  serializer can accept a frame (IDLE only)
//   i_frame_data   in   [FRAM_SIZE-1:0] frame payload, bit 0 sent first
//   i_frame_mode   in   0 = normal (NORM_MOD bits), 1 = debug (DEBUG_MOD bits)
//   o_tx_data      out  serial data bit, forced to 0 when not valid
//   o_tx_valid     out  o_tx_data holds a valid bit
//   i_tx_ready     in   host accepts the current bit
//   o_busy         out  frame in flight (SHIFT or DONE)
//   o_frame_done   out  one-cycle pulse after the last bit is accepted
// -----------------------------------------------------------------------------
module puf_tx_serializer #(
   parameter int FRAM_SIZE = 160,
   parameter int NORM_MOD  = 34,
   parameter int DEBUG_MOD = 157
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_frame_valid,
   output logic                 o_frame_ready,
   input  logic [FRAM_SIZE-1:0] i_frame_data,
   input  logic                 i_frame_mode,
   output logic                 o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic                 o_busy,
   output logic                 o_frame_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // The bit counter is 8 bits wide, so both lengths must stay at or below 255.
   localparam logic [7:0] NORM_LEN  = 8'(NORM_MOD);
   localparam logic [7:0] DEBUG_LEN = 8'(DEBUG_MOD);

   logic [1:0]           r_state;
   logic [FRAM_SIZE-1:0] r_shift;
   logic [7:0]           r_len;
   logic [7:0]           r_cnt;

   logic w_accept;
   logic w_xfer;
   logic w_last;

   assign w_accept = i_frame_valid && (r_state == ST_IDLE);
   assign w_xfer   = (r_state == ST_SHIFT) && i_tx_ready;
   // Compare against the latched length, so a mode change in flight is ignored.
   assign w_last   = (r_cnt == (r_len - 8'd1));

   // NOTE: every register here, including the wide shift register, is cleared
   // by the asynchronous reset. A frame cut off by reset must leave no residual
   // bits behind, so the data path is reset along with the control path.
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shift <= i_frame_data;
                  r_len   <= i_frame_mode ? DEBUG_LEN : NORM_LEN;
                  r_cnt   <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // With the host stalled, nothing here changes, so data and
               // count hold.
               if (w_xfer) begin
                  r_shift <= {1'b0, r_shift[FRAM_SIZE-1:1]};
                  r_cnt   <= r_cnt + 8'd1;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // All outputs decode straight from state, so reset forces them the same
   // cycle without waiting for a clock edge.
   assign o_frame_ready = (r_state == ST_IDLE);
   assign o_tx_valid    = (r_state == ST_SHIFT);
   assign o_tx_data     = (r_state == ST_SHIFT) && r_shift[0];
   assign o_busy        = (r_state == ST_SHIFT) || (r_state == ST_DONE);
   assign o_frame_done  = (r_state == ST_DONE);

endmodule
